mem_stage: RTL and testbench

//  Memory-access stage directly downstream of the execute stage. Takes the registered EX/MEM

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_align.sv | 40 ++++
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: mem_ctrl bit positions, access sizes, FSM states.
// Optional feature macro: MEM_MISALIGN_EN (see mem_stage.sv).
package mem_stage_pkg;

  localparam int unsigned CTRL_LOAD  = 4;
  localparam int unsigned CTRL_STORE = 3;
  localparam int unsigned CTRL_UNS   = 2;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } mem_state_e;

  // Size code 2'b11 falls into the word branch in both helpers.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_B:   return lo;
      MEM_H:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational byte-enable / store-data lane replication and load lane-select with
// sign or zero extension. 32-bit data bus, four byte lanes.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] din_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o     = '1;
    wdata_o  = din_i;
    ldata_o  = rdata_i;
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{din_i[7:0]}};
        ldata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{din_i[15:0]}};
        ldata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage driving the req/gnt/rvalid data bus and stalling until done.
// Define MEM_MISALIGN_EN to flag misaligned H/W accesses instead of forcing natural alignment.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     EX_MEM_alu_res,
  input  logic [DATA_W-1:0]     EX_MEM_mem_din,
  input  logic [4:0]            EX_MEM_mem_ctrl,
  input  logic                  EX_MEM_vld,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W/8-1:0]   dmem_be,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic [DATA_W-1:0]     MEM_data,
  output logic                  MEM_vld,
  output logic                  MEM_stall,
  output logic                  MEM_misalign
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              is_store, mem_op, mis, issue;
  logic [1:0]        addr_lo;
  logic [DATA_W-1:0] ldata;
  logic              req_c, vld_c, stall_c;

  // A set store bit wins over the load bit.
  assign is_store = EX_MEM_mem_ctrl[CTRL_STORE];
  assign mem_op   = EX_MEM_vld & (EX_MEM_mem_ctrl[CTRL_LOAD] | is_store);

`ifdef MEM_MISALIGN_EN
  assign mis     = mem_op & misaligned(EX_MEM_mem_ctrl[1:0], EX_MEM_alu_res[1:0]);
  assign addr_lo = EX_MEM_alu_res[1:0];
`else
  assign mis     = 1'b0;
  assign addr_lo = align_lo(EX_MEM_mem_ctrl[1:0], EX_MEM_alu_res[1:0]);
`endif

  mem_align u_align (
    .size_i    (EX_MEM_mem_ctrl[1:0]),
    .addr_lo_i (addr_lo),
    .uns_i     (EX_MEM_mem_ctrl[CTRL_UNS]),
    .din_i     (EX_MEM_mem_din),
    .rdata_i   (dmem_rdata),
    .be_o      (dmem_be),
    .wdata_o   (dmem_wdata),
    .ldata_o   (ldata)
  );

  assign dmem_addr = {EX_MEM_alu_res[ADDR_W-1:2], 2'b00};
  assign dmem_we   = is_store;
  assign issue     = (state_q == S_REQ) | ((state_q == S_IDLE) & mem_op & ~mis);

  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    req_c    = 1'b0;
    vld_c    = 1'b0;
    stall_c  = 1'b0;
    MEM_data = EX_MEM_alu_res;
    if (issue) begin
      req_c   = 1'b1;
      vld_c   = dmem_gnt & is_store;
      stall_c = ~(dmem_gnt & is_store);
      if (dmem_gnt) state_d = is_store ? S_IDLE : S_WAIT;
      else          state_d = S_REQ;
    end else begin
      case (state_q)
        S_IDLE: vld_c = EX_MEM_vld & ~mem_op;
        S_WAIT: begin
          stall_c = 1'b1;
          if (dmem_rvalid) begin
            load_d  = ldata;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          MEM_data = load_q;
          vld_c    = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held, independent of the EX/MEM inputs.
  assign dmem_req     = req_c & rst;
  assign MEM_vld      = vld_c & rst;
  assign MEM_stall    = stall_c & rst;
  assign MEM_misalign = (state_q == S_IDLE) & mis & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table driven through a scoreboard, plus reset,
// invalid-instruction and misalignment sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_MEM_alu_res, EX_MEM_mem_din;
  logic [4:0]  EX_MEM_mem_ctrl;
  logic        EX_MEM_vld;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] MEM_data;
  logic        MEM_vld, MEM_stall, MEM_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .EX_MEM_alu_res  (EX_MEM_alu_res),
    .EX_MEM_mem_din  (EX_MEM_mem_din),
    .EX_MEM_mem_ctrl (EX_MEM_mem_ctrl),
    .EX_MEM_vld      (EX_MEM_vld),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .MEM_data        (MEM_data),
    .MEM_vld         (MEM_vld),
    .MEM_stall       (MEM_stall),
    .MEM_misalign    (MEM_misalign)
  );

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] din;
    logic [4:0]  ctrl;
    int unsigned g;      // cycle of gnt, counted from first cycle the op is presented
    int unsigned r;      // extra cycles between WAIT entry and rvalid
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    int unsigned stalls;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    bit          mem, st, done, req_ok;
    int unsigned exp_stalls, stalls;
    exp_t        e;
    mem = v.ctrl[4] | v.ctrl[3];
    st  = v.ctrl[3];
    exp_stalls = !mem ? 0 : (st ? v.g : v.g + 2 + v.r);
    sbq.push_back('{v.name, v.data, exp_stalls});
    EX_MEM_alu_res  = v.alu;
    EX_MEM_mem_din  = v.din;
    EX_MEM_mem_ctrl = v.ctrl;
    EX_MEM_vld      = 1'b1;
    done = 0; req_ok = 1; stalls = 0;
    for (int unsigned c = 0; c < 40 && !done; c++) begin
      dmem_gnt    = mem && (c == v.g);
      dmem_rvalid = mem && !st && (c == v.g + 1 + v.r);
      dmem_rdata  = dmem_rvalid ? v.rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (mem && c <= v.g && !dmem_req) req_ok = 0;
      if ((!mem || c > v.g) && dmem_req) req_ok = 0;
      if (mem && c == 0) check({v.name, " misalign"}, {31'd0, MEM_misalign}, 32'd0);
      if (mem && c == v.g) begin
        check({v.name, " addr"}, dmem_addr, {v.alu[31:2], 2'b00});
        check({v.name, " be"}, {28'd0, dmem_be}, {28'd0, v.be});
        check({v.name, " we"}, {31'd0, dmem_we}, {31'd0, st});
        if (st) check({v.name, " wdata"}, dmem_wdata, v.wdata);
      end
      if (MEM_stall) stalls++;
      if (MEM_vld) begin
        done = 1;
        if (sbq.size() == 0) begin
          check({v.name, " unexpected vld"}, 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check({e.name, " data"}, MEM_data, e.data);
          check({e.name, " stalls"}, stalls, e.stalls);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check({v.name, " timeout"}, 32'd0, 32'd1);
      void'(sbq.pop_front());
    end
    check({v.name, " req"}, {31'd0, req_ok}, 32'd1);
    EX_MEM_vld  = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            name     alu           din           ctrl      g  r  rdata         be       wdata         data
    vecs.push_back('{"ADD",  32'h0000_1234, 32'h0,        5'b00000, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_1234});
    vecs.push_back('{"SB",   32'h0000_0103, 32'h0000_00AB, 5'b01000, 0, 0, 32'h0,        4'b1000, 32'hABAB_ABAB, 32'h0000_0103});
    vecs.push_back('{"LB",   32'h0000_0101, 32'h0,        5'b10000, 0, 0, 32'h0000_8000, 4'b0010, 32'h0,        32'hFFFF_FF80});
    vecs.push_back('{"LHU",  32'h0000_0102, 32'h0,        5'b10101, 3, 0, 32'hBEEF_0000, 4'b1100, 32'h0,        32'h0000_BEEF});
    vecs.push_back('{"SH",   32'h0000_0102, 32'h1234_5678, 5'b01001, 1, 0, 32'h0,        4'b1100, 32'h5678_5678, 32'h0000_0102});
    vecs.push_back('{"SW",   32'h0000_0200, 32'hDEAD_BEEF, 5'b01010, 0, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0000_0200});
    vecs.push_back('{"LW",   32'h0000_0300, 32'h0,        5'b10010, 0, 2, 32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D});
    vecs.push_back('{"LH",   32'h0000_0100, 32'h0,        5'b10001, 2, 1, 32'h1234_8001, 4'b0011, 32'h0,        32'hFFFF_8001});
    vecs.push_back('{"LBU",  32'h0000_0103, 32'h0,        5'b10100, 0, 0, 32'h9A00_0000, 4'b1000, 32'h0,        32'h0000_009A});
    vecs.push_back('{"LBp",  32'h0000_0100, 32'h0,        5'b10000, 1, 0, 32'hFFFF_FF7F, 4'b0001, 32'h0,        32'h0000_007F});
    vecs.push_back('{"LDST", 32'h0000_0400, 32'h1122_3344, 5'b11010, 0, 0, 32'h0,        4'b1111, 32'h1122_3344, 32'h0000_0400});
    vecs.push_back('{"LSZ3", 32'h0000_0500, 32'h0,        5'b10011, 0, 0, 32'h8000_0001, 4'b1111, 32'h0,        32'h8000_0001});
`ifndef MEM_MISALIGN_EN
    vecs.push_back('{"LWmis", 32'h0000_0102, 32'h0,       5'b10010, 0, 0, 32'h0102_0304, 4'b1111, 32'h0,        32'h0102_0304});
    vecs.push_back('{"LHmis", 32'h0000_0103, 32'h0,       5'b10001, 0, 0, 32'hABCD_1234, 4'b1100, 32'h0,        32'hFFFF_ABCD});
    vecs.push_back('{"SHmis", 32'h0000_0101, 32'h0000_BEEF, 5'b01001, 0, 0, 32'h0,      4'b0011, 32'hBEEF_BEEF, 32'h0000_0101});
`endif

    rst = 1'b0;
    EX_MEM_alu_res = 32'h100; EX_MEM_mem_din = '0; EX_MEM_mem_ctrl = 5'b10010; EX_MEM_vld = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    check("reset req",      {31'd0, dmem_req},     32'd0);
    check("reset vld",      {31'd0, MEM_vld},      32'd0);
    check("reset stall",    {31'd0, MEM_stall},    32'd0);
    check("reset misalign", {31'd0, MEM_misalign}, 32'd0);
    EX_MEM_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    @(negedge clk);
    check("novld vld",   {31'd0, MEM_vld},   32'd0);
    check("novld req",   {31'd0, dmem_req},  32'd0);
    check("novld stall", {31'd0, MEM_stall}, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset while a load waits for rvalid, then a stray rvalid in IDLE.
    EX_MEM_alu_res = 32'h300; EX_MEM_mem_ctrl = 5'b10010; EX_MEM_vld = 1'b1; dmem_gnt = 1'b1;
    @(negedge clk);
    check("rstw req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("rstw wait stall", {31'd0, MEM_stall}, 32'd1);
    rst = 1'b0;
    #1;
    check("rstw req0",   {31'd0, dmem_req},  32'd0);
    check("rstw vld0",   {31'd0, MEM_vld},   32'd0);
    check("rstw stall0", {31'd0, MEM_stall}, 32'd0);
    EX_MEM_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("late rvalid stall", {31'd0, MEM_stall}, 32'd0);
    check("late rvalid vld",   {31'd0, MEM_vld},   32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("late rvalid no done", {31'd0, MEM_vld}, 32'd0);
    @(posedge clk); #1;
    v = '{"post-rst SW", 32'h0000_0600, 32'h0BAD_F00D, 5'b01010, 2, 0, 32'h0, 4'b1111, 32'h0BAD_F00D, 32'h0000_0600};
    run_op(v);

`ifdef MEM_MISALIGN_EN
    EX_MEM_alu_res = 32'h102; EX_MEM_mem_ctrl = 5'b10010; EX_MEM_vld = 1'b1; dmem_gnt = 1'b0;
    @(negedge clk);
    check("LW mis flag",  {31'd0, MEM_misalign}, 32'd1);
    check("LW mis req",   {31'd0, dmem_req},     32'd0);
    check("LW mis stall", {31'd0, MEM_stall},    32'd0);
    check("LW mis vld",   {31'd0, MEM_vld},      32'd0);
    @(posedge clk); #1;
    EX_MEM_alu_res = 32'h101; EX_MEM_mem_ctrl = 5'b01001;
    @(negedge clk);
    check("SH mis flag", {31'd0, MEM_misalign}, 32'd1);
    check("SH mis req",  {31'd0, dmem_req},     32'd0);
    @(posedge clk); #1;
    EX_MEM_vld = 1'b0;
    @(negedge clk);
    check("mis clear", {31'd0, MEM_misalign}, 32'd0);
    @(posedge clk); #1;
`endif

    check("scoreboard empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
